// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronised IRQ lines latch into PENDING, then are masked and routed to INT0/INT1.
// Latency: IRQ sampled at edge k -> PENDING after k+SYNC_STAGES -> INT0/INT1 after k+SYNC_STAGES+1.
// Backpressure: none; reads are combinational, each write strobe commits once on its falling edge.
module interrupt_controller #(
  parameter int          NUM_SRC     = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [15:0]        ADDR,
  input  logic [15:0]        WDATA,
  input  logic               RDN,
  input  logic               WRN0,
  input  logic               WRN1,
  output logic [15:0]        RDATA,
  output logic               IC_SEL,
  input  logic [NUM_SRC-1:0] IRQ,
  output logic               INT0,
  output logic               INT1
);

  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_PRIO = 3'd2;
  localparam logic [2:0] REG_EDGE = 3'd3;
  localparam logic [2:0] REG_VEC  = 3'd4;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] irq_s, irq_prev;
  logic [NUM_SRC-1:0] pend, mask, prio, edge_sel;
  logic [NUM_SRC-1:0] pend_nxt, lane, wdat, w1c;
  logic [NUM_SRC-1:0] vec_g0, vec_g1;
  logic [3:0]         vec_idx0, vec_idx1;
  logic [15:0]        vector;
  logic               wrn0_q, wrn1_q;
  logic               hit, commit_lo, commit_hi, wr_any;
  logic               wr_pend, wr_mask, wr_prio, wr_edge;
  logic [2:0]         reg_idx;
  logic [16-NUM_SRC:0] unused_bits;

  assign unused_bits = {ADDR[0], WDATA[15:NUM_SRC]};

  assign irq_s   = sync_q[SYNC_STAGES-1];
  assign hit     = (ADDR[15:4] == BASE_ADDR[15:4]);
  assign reg_idx = ADDR[3:1];
  assign IC_SEL  = hit & ~RDN;

  // A commit needs the strobe to have been high on the previous edge, so a held strobe writes once.
  assign commit_lo = ~WRN0 & wrn0_q;
  assign commit_hi = ~WRN1 & wrn1_q;
  assign wr_any    = hit & (commit_lo | commit_hi);
  assign wr_pend   = wr_any && (reg_idx == REG_PEND);
  assign wr_mask   = wr_any && (reg_idx == REG_MASK);
  assign wr_prio   = wr_any && (reg_idx == REG_PRIO);
  assign wr_edge   = wr_any && (reg_idx == REG_EDGE);
  assign wdat      = WDATA[NUM_SRC-1:0];
  assign w1c       = wr_pend ? (wdat & lane) : '0;

  always_comb begin
    lane     = '0;
    pend_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lane[i] = (i < 8) ? commit_lo : commit_hi;
      // A fresh edge in the same cycle as a W1C keeps the bit set.
      if (edge_sel[i])
        pend_nxt[i] = (pend[i] & ~w1c[i]) | (irq_s[i] & ~irq_prev[i]);
      else
        pend_nxt[i] = irq_s[i];
    end
  end

  always_comb begin
    vec_g0   = pend & mask & prio;
    vec_g1   = pend & mask & ~prio;
    vec_idx0 = '0;
    vec_idx1 = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec_g0[i]) vec_idx0 = 4'(i);
      if (vec_g1[i]) vec_idx1 = 4'(i);
    end
    vector = '0;
    if (|vec_g0)
      vector = {1'b1, 10'd0, 1'b0, vec_idx0};
    else if (|vec_g1)
      vector = {1'b1, 10'd0, 1'b1, vec_idx1};
  end

  always_comb begin
    RDATA = '0;
    if (IC_SEL) begin
      case (reg_idx)
        REG_PEND: RDATA = 16'(pend);
        REG_MASK: RDATA = 16'(mask);
        REG_PRIO: RDATA = 16'(prio);
        REG_EDGE: RDATA = 16'(edge_sel);
        REG_VEC:  RDATA = vector;
        default:  RDATA = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q   <= '0;
      irq_prev <= '0;
      wrn0_q   <= 1'b1;
      wrn1_q   <= 1'b1;
      pend     <= '0;
      mask     <= '0;
      prio     <= '0;
      edge_sel <= '1;
      INT0     <= 1'b0;
      INT1     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], IRQ};
      irq_prev <= irq_s;
      wrn0_q   <= WRN0;
      wrn1_q   <= WRN1;
      pend     <= pend_nxt;
      if (wr_mask) mask     <= (mask & ~lane) | (wdat & lane);
      if (wr_prio) prio     <= (prio & ~lane) | (wdat & lane);
      if (wr_edge) edge_sel <= (edge_sel & ~lane) | (wdat & lane);
      INT0     <= |(pend & mask & prio);
      INT1     <= |(pend & mask & ~prio);
    end
  end

endmodule
